montre_bcd_clock: RTL and testbench

Avalon-MM 16-bit slave that keeps watch time in BCD (HH:MM:SS) and a BCD alarm.
- Sits directly downstream of the interval timer. It consumes the timer's one-cycle timeout pulse on tick_in; the timer runs continuously at 1 s or a sub-multiple of it.
- Exposes time and alarm to the Nios II, and drives time_bcd straight to the 7-segment decoder.
- Raises irq on second and/or alarm events.

---
 rtl/montre_bcd_clock.sv | 155 +++++++++++++++
 tb/tb_montre_bcd_clock.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/montre_bcd_clock.sv
// BCD watch-time keeper (HH:MM:SS) with alarm, Avalon-MM 16-bit slave, fed by interval-timer ticks.
// Optional `MONTRE_CLOCK_12H_EN selects 12-hour mode with a PM flag in TIME_HI[8].
module montre_bcd_clock #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick_in,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq,
  output logic [23:0] time_bcd
);

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
  } hms_t;

  localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);
`ifdef MONTRE_CLOCK_12H_EN
  localparam logic [7:0] HH_RST = 8'h12;
`else
  localparam logic [7:0] HH_RST = 8'h00;
`endif

  hms_t        tm, tm_adv;
  logic [7:0]  al_hh, al_mm;
  logic [3:0]  ctrl;
  logic [1:0]  status, st_clr;
  logic [15:0] presc, rd_mux;
  logic        wr, qual_tick, sec_adv, alarm_hit;
  logic        wr_lo, wr_hi, wr_al, wr_time;
`ifdef MONTRE_CLOCK_12H_EN
  logic        pm, pm_adv;
`endif

  function automatic logic bcd_ok(input logic [7:0] b, input logic [7:0] max);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (b <= max);
  endfunction

  function automatic logic hour_ok(input logic [7:0] b);
`ifdef MONTRE_CLOCK_12H_EN
    return bcd_ok(b, 8'h12) && (b != 8'h00);
`else
    return bcd_ok(b, 8'h23);
`endif
  endfunction

  function automatic logic [7:0] inc_bcd(input logic [7:0] b);
    return (b[3:0] == 4'd9) ? {b[7:4] + 4'd1, 4'd0} : {b[7:4], b[3:0] + 4'd1};
  endfunction

  // Whole-second carry chain resolved in one cycle
  always_comb begin
    tm_adv = tm;
`ifdef MONTRE_CLOCK_12H_EN
    pm_adv = pm;
`endif
    if (tm.ss == 8'h59) begin
      tm_adv.ss = 8'h00;
      if (tm.mm == 8'h59) begin
        tm_adv.mm = 8'h00;
`ifdef MONTRE_CLOCK_12H_EN
        tm_adv.hh = (tm.hh == 8'h12) ? 8'h01 : inc_bcd(tm.hh);
        if (tm.hh == 8'h11) pm_adv = ~pm;
`else
        tm_adv.hh = (tm.hh == 8'h23) ? 8'h00 : inc_bcd(tm.hh);
`endif
      end else begin
        tm_adv.mm = inc_bcd(tm.mm);
      end
    end else begin
      tm_adv.ss = inc_bcd(tm.ss);
    end
  end

  assign wr        = chipselect && !write_n;
  assign qual_tick = tick_in && ctrl[0];
  assign sec_adv   = qual_tick && (presc == DIV_LAST);
  assign wr_lo     = wr && (address == 3'd0) && bcd_ok(writedata[15:8], 8'h59) && bcd_ok(writedata[7:0], 8'h59);
  assign wr_hi     = wr && (address == 3'd1) && hour_ok(writedata[7:0]);
  assign wr_al     = wr && (address == 3'd2) && hour_ok(writedata[15:8]) && bcd_ok(writedata[7:0], 8'h59);
  assign wr_time   = wr_lo || wr_hi;
  assign st_clr    = (wr && (address == 3'd4)) ? writedata[1:0] : 2'b00;
  // A time write in the same cycle discards the advance, so no alarm can match on it
  assign alarm_hit = sec_adv && !wr_time && ctrl[1] &&
                     (tm_adv.hh == al_hh) && (tm_adv.mm == al_mm) && (tm_adv.ss == 8'h00);
  assign time_bcd  = tm;

  always_comb begin
    rd_mux = 16'h0000;
    case (address)
      3'd0: rd_mux = {tm.mm, tm.ss};
`ifdef MONTRE_CLOCK_12H_EN
      3'd1: rd_mux = {7'd0, pm, tm.hh};
`else
      3'd1: rd_mux = {8'd0, tm.hh};
`endif
      3'd2: rd_mux = {al_hh, al_mm};
      3'd3: rd_mux = {12'd0, ctrl};
      3'd4: rd_mux = {14'd0, status};
      default: rd_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tm       <= '{hh: HH_RST, mm: 8'h00, ss: 8'h00};
`ifdef MONTRE_CLOCK_12H_EN
      pm       <= 1'b0;
`endif
      al_hh    <= 8'h00;
      al_mm    <= 8'h00;
      ctrl     <= 4'h0;
      status   <= 2'b00;
      presc    <= 16'h0000;
      readdata <= 16'h0000;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_mux;
      irq      <= (status[0] && ctrl[2]) || (status[1] && ctrl[3]);
      if (wr_time)        presc <= 16'h0000;
      else if (qual_tick) presc <= sec_adv ? 16'h0000 : presc + 16'd1;
      if (sec_adv && !wr_time) begin
        tm <= tm_adv;
`ifdef MONTRE_CLOCK_12H_EN
        pm <= pm_adv;
`endif
      end
      if (wr_lo) begin
        tm.mm <= writedata[15:8];
        tm.ss <= writedata[7:0];
      end
      if (wr_hi) begin
        tm.hh <= writedata[7:0];
`ifdef MONTRE_CLOCK_12H_EN
        pm    <= writedata[8];
`endif
      end
      if (wr_al) begin
        al_hh <= writedata[15:8];
        al_mm <= writedata[7:0];
      end
      if (wr && (address == 3'd3)) ctrl <= writedata[3:0];
      // New events override a same-cycle clear
      status <= (status & ~st_clr) | {alarm_hit, sec_adv};
    end
  end

endmodule

// File: tb/tb_montre_bcd_clock.sv
// Bench for montre_bcd_clock: two instances (TICK_DIV 1 and 4) on a shared bus, checked against
// a seconds-of-day reference model plus directed scenario constants.
module tb_montre_bcd_clock;
  logic        clk = 1'b0, reset_n = 1'b0, tick_in = 1'b0, chipselect = 1'b0, write_n = 1'b1;
  logic [2:0]  address = 3'd0;
  logic [15:0] writedata = 16'h0000;
  logic [15:0] rd1, rd4;
  logic        irq1, irq4;
  logic [23:0] tb1, tb4;

  always #5 clk = ~clk;

  montre_bcd_clock #(.TICK_DIV(1)) dut1 (.clk(clk), .reset_n(reset_n), .tick_in(tick_in), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata), .readdata(rd1), .irq(irq1), .time_bcd(tb1));
  montre_bcd_clock #(.TICK_DIV(4)) dut4 (.clk(clk), .reset_n(reset_n), .tick_in(tick_in), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata), .readdata(rd4), .irq(irq4), .time_bcd(tb4));

  int total = 0, bad = 0;

`ifdef MONTRE_CLOCK_12H_EN
  localparam int HLO = 1, HHI = 12;
  localparam logic [7:0]  HB = 8'h12;
  localparam logic [15:0] HI_LAST = 16'h0111, HI_ZERO = 16'h0012;
`else
  localparam int HLO = 0, HHI = 23;
  localparam logic [7:0]  HB = 8'h00;
  localparam logic [15:0] HI_LAST = 16'h0023, HI_ZERO = 16'h0000;
`endif

  // Reference model: time is seconds since midnight, one copy per instance
  int          m_sec[2], m_presc[2];
  int          divs[2] = '{1, 4};
  logic [1:0]  m_stat[2];
  logic [15:0] m_alarm;
  logic [3:0]  m_ctrl;
  logic [15:0] e_rd[2];
  logic        e_irq[2];

  function automatic logic [7:0] to_bcd(int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction
  function automatic int from_bcd(logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction
  function automatic bit bcd_in(logic [7:0] b, int lo, int hi);
    return b[7:4] < 4'd10 && b[3:0] < 4'd10 && from_bcd(b) >= lo && from_bcd(b) <= hi;
  endfunction
  function automatic int hour_disp(int s);
`ifdef MONTRE_CLOCK_12H_EN
    return ((s / 3600) % 12 == 0) ? 12 : (s / 3600) % 12;
`else
    return s / 3600;
`endif
  endfunction
  function automatic logic [23:0] disp(int s);
    return {to_bcd(hour_disp(s)), to_bcd((s / 60) % 60), to_bcd(s % 60)};
  endfunction
  function automatic logic [15:0] reg_read(int k, logic [2:0] a);
    int s = m_sec[k];
    logic pm = (s >= 43200);
    case (a)
      3'd0: return {to_bcd((s / 60) % 60), to_bcd(s % 60)};
`ifdef MONTRE_CLOCK_12H_EN
      3'd1: return {7'd0, pm, to_bcd(hour_disp(s))};
`else
      3'd1: return {8'd0, to_bcd(hour_disp(s))};
`endif
      3'd2: return m_alarm;
      3'd3: return {12'd0, m_ctrl};
      3'd4: return {14'd0, m_stat[k]};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_step(input logic tk, input logic w, input logic [2:0] a, input logic [15:0] d);
    for (int k = 0; k < 2; k++) begin
      int s, h;
      bit adv, tw;
      logic [1:0] ev;
      e_rd[k]  = reg_read(k, a);
      e_irq[k] = (m_stat[k][0] && m_ctrl[2]) || (m_stat[k][1] && m_ctrl[3]);
      adv = 0; tw = 0; ev = 2'b00; s = m_sec[k];
      if (tk && m_ctrl[0]) begin
        if (m_presc[k] == divs[k] - 1) begin adv = 1; m_presc[k] = 0; end
        else m_presc[k]++;
      end
      if (w && a == 3'd0 && bcd_in(d[15:8], 0, 59) && bcd_in(d[7:0], 0, 59)) begin
        tw = 1; s = (s / 3600) * 3600 + from_bcd(d[15:8]) * 60 + from_bcd(d[7:0]);
      end
      if (w && a == 3'd1 && bcd_in(d[7:0], HLO, HHI)) begin
        tw = 1; h = from_bcd(d[7:0]);
`ifdef MONTRE_CLOCK_12H_EN
        h = h % 12 + (d[8] ? 12 : 0);
`endif
        s = h * 3600 + s % 3600;
      end
      if (tw) m_presc[k] = 0;
      else if (adv) begin
        s = (s + 1) % 86400;
        if (m_ctrl[1] && disp(s) == {m_alarm, 8'h00}) ev[1] = 1'b1;
      end
      if (adv) ev[0] = 1'b1;
      m_sec[k] = s;
      if (w && a == 3'd4) m_stat[k] = m_stat[k] & ~d[1:0];
      m_stat[k] = m_stat[k] | ev;
    end
    if (w && a == 3'd2 && bcd_in(d[15:8], HLO, HHI) && bcd_in(d[7:0], 0, 59)) m_alarm = d;
    if (w && a == 3'd3) m_ctrl = d[3:0];
  endtask

  task automatic cyc(input logic tk, input logic w, input logic [2:0] a, input logic [15:0] d);
    tick_in = tk; chipselect = w; write_n = !w; address = a; writedata = d;
    model_step(tk, w, a, d);
    @(posedge clk); #1;
    tick_in = 1'b0; chipselect = 1'b0; write_n = 1'b1;
  endtask
  task automatic wr(input logic [2:0] a, input logic [15:0] d); cyc(1'b0, 1'b1, a, d); endtask
  task automatic rd(input logic [2:0] a); cyc(1'b0, 1'b0, a, 16'h0); endtask
  task automatic tick(); cyc(1'b1, 1'b0, 3'd0, 16'h0); endtask

  task automatic test_reset();
    total++; if (rd1 !== 16'h0) begin bad++; $display("FAIL reset_rd got=%h exp=0000", rd1); end
    total++; if (irq1 !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq1); end
    total++; if (tb1 !== {HB, 16'h0}) begin bad++; $display("FAIL reset_time got=%h exp=%h", tb1, {HB, 16'h0}); end
`ifdef MONTRE_CLOCK_12H_EN
    rd(3'd1);
    total++; if (rd1 !== 16'h0012) begin bad++; $display("FAIL reset_hi12 got=%h exp=0012", rd1); end
`endif
    wr(3'd3, 16'h0001);
    repeat (3) tick();
    rd(3'd0);
    total++; if (rd1 !== 16'h0003) begin bad++; $display("FAIL run3_lo got=%h exp=0003", rd1); end
  endtask

  task automatic test_wrap_irq();
    wr(3'd4, 16'h0003);
    wr(3'd1, HI_LAST);
    wr(3'd0, 16'h5959);
    wr(3'd3, 16'h0005);
    tick();
    total++; if (tb1 !== {HB, 16'h0}) begin bad++; $display("FAIL wrap_time got=%h exp=%h", tb1, {HB, 16'h0}); end
    rd(3'd4);
    total++; if (rd1 !== 16'h0001) begin bad++; $display("FAIL wrap_status got=%h exp=0001", rd1); end
    total++; if (irq1 !== 1'b1) begin bad++; $display("FAIL sec_irq got=%b exp=1", irq1); end
    wr(3'd4, 16'h0001);
    rd(3'd4);
    total++; if (irq1 !== 1'b0) begin bad++; $display("FAIL sec_irq_clr got=%b exp=0", irq1); end
  endtask

  task automatic test_validation();
    wr(3'd0, 16'h1234);
    wr(3'd0, 16'h0060);
    wr(3'd0, 16'h001A);
    wr(3'd1, 16'h0024);
    wr(3'd2, 16'h0A00);
    rd(3'd0);
    total++; if (rd1 !== 16'h1234) begin bad++; $display("FAIL rej_lo got=%h exp=1234", rd1); end
    rd(3'd1);
    total++; if (rd1 !== {8'h00, HB}) begin bad++; $display("FAIL rej_hi got=%h exp=%h", rd1, {8'h00, HB}); end
    rd(3'd2);
    total++; if (rd1 !== 16'h0000) begin bad++; $display("FAIL rej_alarm got=%h exp=0000", rd1); end
  endtask

  task automatic test_alarm();
    wr(3'd2, 16'h0705);
    wr(3'd1, 16'h0007);
    wr(3'd0, 16'h0459);
    wr(3'd3, 16'h000B);
    wr(3'd4, 16'h0003);
    tick();
    total++; if (tb1 !== 24'h070500) begin bad++; $display("FAIL alarm_time got=%h exp=070500", tb1); end
    rd(3'd4);
    total++; if (rd1 !== 16'h0003) begin bad++; $display("FAIL alarm_status got=%h exp=0003", rd1); end
    total++; if (irq1 !== 1'b1) begin bad++; $display("FAIL alarm_irq got=%b exp=1", irq1); end
    cyc(1'b1, 1'b1, 3'd4, 16'h0002);
    rd(3'd4);
    total++; if (rd1 !== 16'h0001) begin bad++; $display("FAIL clr_vs_event got=%h exp=0001", rd1); end
    total++; if (irq1 !== 1'b0) begin bad++; $display("FAIL alarm_irq_clr got=%b exp=0", irq1); end
  endtask

  task automatic test_prescaler();
    wr(3'd1, HI_ZERO);
    wr(3'd0, 16'h0000);
    wr(3'd3, 16'h0001);
    repeat (7) tick();
    total++; if (tb4 !== {HB, 16'h0001}) begin bad++; $display("FAIL div4_7 got=%h exp=%h", tb4, {HB, 16'h0001}); end
    wr(3'd0, 16'h1000);
    repeat (3) tick();
    total++; if (tb4 !== {HB, 16'h1000}) begin bad++; $display("FAIL div4_clr got=%h exp=%h", tb4, {HB, 16'h1000}); end
    tick();
    total++; if (tb4 !== {HB, 16'h1001}) begin bad++; $display("FAIL div4_adv got=%h exp=%h", tb4, {HB, 16'h1001}); end
    total++; if (tb1 !== {HB, 16'h1004}) begin bad++; $display("FAIL div1_4 got=%h exp=%h", tb1, {HB, 16'h1004}); end
    cyc(1'b1, 1'b1, 3'd0, 16'h2000);
    total++; if (tb1 !== {HB, 16'h2000}) begin bad++; $display("FAIL write_wins got=%h exp=%h", tb1, {HB, 16'h2000}); end
    total++; if (tb4 !== {HB, 16'h2000}) begin bad++; $display("FAIL write_wins4 got=%h exp=%h", tb4, {HB, 16'h2000}); end
  endtask

`ifdef MONTRE_CLOCK_12H_EN
  task automatic test_12h();
    wr(3'd3, 16'h0001);
    wr(3'd1, 16'h0011);
    wr(3'd0, 16'h5959);
    tick();
    rd(3'd1);
    total++; if (rd1 !== 16'h0112) begin bad++; $display("FAIL pm_toggle got=%h exp=0112", rd1); end
    rd(3'd0);
    total++; if (rd1 !== 16'h0000) begin bad++; $display("FAIL pm_lo got=%h exp=0000", rd1); end
    wr(3'd1, 16'h0112);
    wr(3'd0, 16'h5959);
    tick();
    rd(3'd1);
    total++; if (rd1 !== 16'h0101) begin bad++; $display("FAIL h12_to_1 got=%h exp=0101", rd1); end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      logic tk, w;
      logic [2:0] a;
      logic [15:0] d;
      logic [7:0] hh, mm, ss;
      tk = 1'($urandom_range(0, 1));
      w  = ($urandom_range(0, 7) < 2);
      a  = w ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 7));
      hh = to_bcd($urandom_range(HLO, HHI));
      mm = to_bcd($urandom_range(0, 59));
      ss = to_bcd($urandom_range(0, 59));
      if ($urandom_range(0, 2) != 0) begin
        case (a)
          3'd0: d = {mm, ss};
          3'd1: d = {7'd0, 1'($urandom_range(0, 1)), hh};
          3'd2: d = {hh, mm};
          3'd3: d = {12'd0, 4'($urandom_range(0, 15)) | 4'b0001};
          default: d = 16'($urandom_range(0, 3));
        endcase
      end else d = 16'($urandom);
      cyc(tk, w, a, d);
      total++; if (tb1 !== disp(m_sec[0])) begin bad++; $display("FAIL rnd_time1 n=%0d got=%h exp=%h", n, tb1, disp(m_sec[0])); end
      total++; if (tb4 !== disp(m_sec[1])) begin bad++; $display("FAIL rnd_time4 n=%0d got=%h exp=%h", n, tb4, disp(m_sec[1])); end
      total++; if (rd1 !== e_rd[0]) begin bad++; $display("FAIL rnd_rd1 n=%0d got=%h exp=%h", n, rd1, e_rd[0]); end
      total++; if (rd4 !== e_rd[1]) begin bad++; $display("FAIL rnd_rd4 n=%0d got=%h exp=%h", n, rd4, e_rd[1]); end
      total++; if (irq1 !== e_irq[0]) begin bad++; $display("FAIL rnd_irq1 n=%0d got=%b exp=%b", n, irq1, e_irq[0]); end
      total++; if (irq4 !== e_irq[1]) begin bad++; $display("FAIL rnd_irq4 n=%0d got=%b exp=%b", n, irq4, e_irq[1]); end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin m_sec[k] = 0; m_presc[k] = 0; m_stat[k] = 2'b00; end
    m_alarm = 16'h0; m_ctrl = 4'h0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_wrap_irq();
    test_validation();
    test_alarm();
    test_prescaler();
`ifdef MONTRE_CLOCK_12H_EN
    test_12h();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
